// File: rtl/pool_layer_mc.sv
// pool_layer_mc: C-channel streaming KxK max/average pooling with internal row/col counters
// and a per-output-column partial-result line buffer.
module pool_layer_mc #(
    parameter int C  = 6,
    parameter int W  = 16,
    parameter int IM = 28,
    parameter int K  = 2,
    localparam int OW = IM / K,
    localparam int OB = ($clog2(OW) > 0) ? $clog2(OW) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [C*W-1:0]  in_data,
    input  logic            mode,
    output logic            out_valid,
    output logic [C*W-1:0]  out_data,
    output logic [OB-1:0]   out_col,
    output logic [OB-1:0]   out_row,
    output logic            finish
);
    localparam int CB = $clog2(IM);
    localparam int LK = $clog2(K);
    localparam int A  = W + 2 * LK;

    generate
        if (K != 2 && K != 4 && K != 8) begin : g_bad_k
            $error("pool_layer_mc: K must be 2, 4 or 8");
        end
    endgenerate

    logic [CB-1:0] col, row;
    logic [OB-1:0] oc, orw;
    logic m, md, act, first, done, last;
    logic [A-1:0] lb [OW][C];
    logic signed [A-1:0] p [C];
    logic signed [A-1:0] e [C];
    logic signed [A-1:0] comb [C];

    // mode is taken live on pixel (0,0) so the first beat already uses the new frame's mode
    always_comb begin
        md    = (row == '0 && col == '0) ? mode : m;
        act   = in_valid && int'(col) < OW * K && int'(row) < OW * K;
        first = col[LK-1:0] == '0 && row[LK-1:0] == '0;
        done  = &col[LK-1:0] && &row[LK-1:0];
        oc    = OB'(col >> LK);
        orw   = OB'(row >> LK);
        last  = int'(oc) == OW - 1 && int'(orw) == OW - 1;
        for (int c = 0; c < C; c++) begin
            p[c]    = A'($signed(in_data[c*W +: W]));
            e[c]    = $signed(lb[oc][c]);
            comb[c] = first ? p[c] : md ? e[c] + p[c] : (p[c] > e[c] ? p[c] : e[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            m         <= 1'b0;
            out_valid <= 1'b0;
            finish    <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            out_valid <= act && done;
            finish    <= act && done && last;
            if (in_valid) begin
                col <= (col == CB'(IM - 1)) ? '0 : col + 1'b1;
                if (col == CB'(IM - 1))
                    row <= (row == CB'(IM - 1)) ? '0 : row + 1'b1;
                if (row == '0 && col == '0)
                    m <= mode;
            end
            if (act && done) begin
                out_col <= oc;
                out_row <= orw;
                for (int c = 0; c < C; c++)
                    out_data[c*W +: W] <= md ? W'(comb[c] >>> (2 * LK)) : comb[c][W-1:0];
            end
        end
    end

    // completed windows go straight to the output register, so the entry is free for the next window row
    always_ff @(posedge clk) begin
        if (act && !done)
            for (int c = 0; c < C; c++)
                lb[oc][c] <= comb[c];
    end
endmodule

// File: tb/tb_pool_layer_mc.sv
// tb_pool_layer_mc: directed/random checks of pool_layer_mc against an arithmetic window model.
module tb_pool_layer_mc;
    localparam int K = 2;

    typedef struct {
        logic [15:0] d;
        int r;
        int c;
        bit f;
    } ev_t;

    logic clk = 0, reset = 1, iv = 0, mode = 0, sel = 0;
    logic [15:0] in_data = '0;
    logic ova, ovb, fa, fb;
    logic [15:0] oda, odb;
    logic [0:0] oca, ora, ocb, orb;

    ev_t obs[$];
    ev_t expq[$];
    int fr [2][8][8];
    int cyc = 0, fin_cyc = -1, beat_cyc = -2;
    int n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool_layer_mc #(.C(2), .W(8), .IM(4), .K(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(iv && !sel), .in_data(in_data), .mode(mode),
        .out_valid(ova), .out_data(oda), .out_col(oca), .out_row(ora), .finish(fa));

    pool_layer_mc #(.C(2), .W(8), .IM(5), .K(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(iv && sel), .in_data(in_data), .mode(mode),
        .out_valid(ovb), .out_data(odb), .out_col(ocb), .out_row(orb), .finish(fb));

    always @(negedge clk) begin
        if (ova) obs.push_back('{oda, int'(ora), int'(oca), fa});
        if (ovb) obs.push_back('{odb, int'(orb), int'(ocb), fb});
        if (fa || fb) fin_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int im, input bit directed);
        for (int r = 0; r < im; r++)
            for (int c = 0; c < im; c++) begin
                fr[0][r][c] = directed ? r * 4 + c + 1 : int'($urandom_range(0, 40)) - 20;
                fr[1][r][c] = directed ? -fr[0][r][c] : int'($urandom_range(0, 40)) - 20;
            end
    endtask

    // nb < 0 streams the whole frame; otherwise stops after nb beats
    task automatic drive(input int im, input bit md, input bit gaps, input bit tog, input int nb);
        int n = 0;
        for (int r = 0; r < im; r++)
            for (int c = 0; c < im; c++) begin
                if (nb >= 0 && n >= nb) return;
                if (gaps)
                    repeat ($urandom_range(0, 2)) begin
                        iv = 0;
                        mode = tog ? 1'($urandom_range(0, 1)) : md;
                        @(negedge clk);
                    end
                iv = 1;
                in_data = {8'(fr[1][r][c]), 8'(fr[0][r][c])};
                mode = (r == 0 && c == 0 || !tog) ? md : 1'($urandom_range(0, 1));
                if (r == (im / K) * K - 1 && c == (im / K) * K - 1) beat_cyc = cyc;
                n++;
                @(negedge clk);
            end
        iv = 0;
    endtask

    task automatic model(input int im, input bit md);
        int ow = im / K;
        for (int orow = 0; orow < ow; orow++)
            for (int ocol = 0; ocol < ow; ocol++) begin
                ev_t ev;
                ev.r = orow;
                ev.c = ocol;
                ev.f = (orow == ow - 1 && ocol == ow - 1);
                ev.d = '0;
                for (int ch = 0; ch < 2; ch++) begin
                    int best = -100000, sum = 0, q;
                    for (int dr = 0; dr < K; dr++)
                        for (int dc = 0; dc < K; dc++) begin
                            int v = fr[ch][orow * K + dr][ocol * K + dc];
                            if (v > best) best = v;
                            sum += v;
                        end
                    q = sum / (K * K);
                    if (sum % (K * K) != 0 && sum < 0) q--;
                    ev.d[ch*8 +: 8] = 8'(md ? q : best);
                end
                expq.push_back(ev);
            end
    endtask

    task automatic check(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, " count"}, obs.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (i < obs.size()) begin
                chk($sformatf("%s[%0d] data", tag, i), obs[i].d, expq[i].d);
                chk($sformatf("%s[%0d] pos", tag, i), obs[i].r * 256 + obs[i].c * 2 + int'(obs[i].f),
                    expq[i].r * 256 + expq[i].c * 2 + int'(expq[i].f));
            end
        obs.delete();
        expq.delete();
    endtask

    task automatic explicit(input string tag, input logic [15:0] ex [4]);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (i < obs.size()) chk($sformatf("%s const[%0d]", tag, i), obs[i].d, ex[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ex_max [4] = '{16'hFF06, 16'hFD08, 16'hF70E, 16'hF510};
        logic [15:0] ex_avg [4] = '{16'hFC03, 16'hFA05, 16'hF40B, 16'hF20D};
        repeat (2) @(negedge clk);
        chk("reset valid/finish", {ova, ovb, fa, fb}, 0);
        chk("reset data", {oda, odb}, 0);
        chk("reset row/col", {ora, oca, orb, ocb}, 0);
        reset = 0;
        @(negedge clk);

        fill(4, 1);
        drive(4, 0, 0, 0, -1);
        explicit("max basic", ex_max);
        model(4, 0);
        check("max basic");

        drive(4, 1, 0, 0, -1);
        explicit("avg basic", ex_avg);
        model(4, 1);
        check("avg basic");

        sel = 1;
        fill(5, 0);
        drive(5, 0, 0, 0, -1);
        model(5, 0);
        check("odd max");
        chk("odd finish latency", fin_cyc, beat_cyc + 1);
        fill(5, 0);
        drive(5, 1, 0, 0, -1);
        model(5, 1);
        check("odd avg");
        sel = 0;

        fill(4, 0);
        drive(4, 1, 1, 1, -1);
        model(4, 1);
        check("gaps avg");
        fill(4, 0);
        drive(4, 0, 1, 1, -1);
        model(4, 0);
        check("gaps max");

        fill(4, 0);
        drive(4, 1, 0, 0, 7);
        reset = 1;
        iv = 1;
        in_data = {8'(fr[1][1][3]), 8'(fr[0][1][3])};
        @(negedge clk);
        reset = 0;
        iv = 0;
        chk("reset mid valid/finish", {ova, fa}, 0);
        obs.delete();
        fill(4, 0);
        drive(4, 0, 0, 0, -1);
        model(4, 0);
        check("after reset");

        fill(4, 0);
        model(4, 1);
        drive(4, 1, 0, 0, -1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                fr[0][r][c] += 100;
                fr[1][r][c] += 100;
            end
        model(4, 1);
        drive(4, 1, 0, 0, -1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (i + 4 < obs.size())
                chk($sformatf("b2b offset[%0d]", i), obs[i + 4].d,
                    {obs[i].d[15:8] + 8'd100, obs[i].d[7:0] + 8'd100});
        check("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_layer_mc.md
Name: pool_layer_mc

Overview:
- Parametrised successor to the fixed six-channel pooling layer. Takes C channels of a row-major IM×IM conv feature map as one packed streaming bus and produces non-overlapping K×K pooled outputs for all channels in lockstep.
- Supports a runtime-selectable max or average mode.
- Keeps its own row/column counters and a per-channel partial-result line buffer, so it needs no external column index.
- Sits between the conv layer output stream and the next layer / output buffer.

Parameters:
- C, 6, number of channels processed in parallel
- W, 16, bits per channel sample, signed two's complement
- IM, 28, input feature-map width and height in pixels
- K, 2, pooling window size and stride. Must be a power of two, 2..8; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data carries one pixel (all C channels) this cycle
- in_data  in  C*W  channel c at bits [c*W+W-1 : c*W]
- mode  in  1  0 = max pool, 1 = average pool. Sampled on the first pixel of each frame.
- out_valid  out  1  out_data holds one pooled pixel this cycle
- out_data  out  C*W  pooled result, same packing as in_data
- out_col  out  clog2(IM/K)  column index of the pooled pixel
- out_row  out  clog2(IM/K)  row index of the pooled pixel
- finish  out  1  one-cycle pulse with the last pooled pixel of a frame

Behaviour:
- **Reset.** On reset=1 at a clock edge, all of the following are cleared, regardless of in_valid in that cycle:
  - out_valid=0, finish=0, out_data=0, out_col=0, out_row=0
  - row/column counters reset to 0
  - latched mode reset to 0
  - line-buffer contents become don't-care
- **Reset mid-frame** discards the partial frame. The next in_valid beat is treated as pixel (0,0).
- **Counters.**
  - col advances 0..IM-1 on every in_valid beat, then wraps to 0 and row advances.
  - row wraps after IM-1; the next beat is a new frame.
  - Gaps between in_valid beats are allowed; there is no backpressure.
- **Mode latch.** mode is latched when in_valid=1 at (0,0). Changes to mode mid-frame are ignored.
- **Trailing pixels.** Let OW=IM/K (floor). Pixels with col>=OW*K or row>=OW*K advance the counters but are otherwise ignored (no output, no buffer write).
- **Line buffer.**
  - One entry per channel per output column (OW×C entries).
  - Entry width is A=W+2*log2(K), which holds the average-mode sum.
  - Entry index is col/K.
- **Combine rule** per channel, for pixel p and entry e:
  - First pixel of a window, (row%K==0 && col%K==0): e := p, sign-extended to A bits.
  - Otherwise, max mode: e := max(e, p), signed compare.
  - Otherwise, avg mode: e := e + p, sign-extended add.
- **Window complete** at row%K==K-1 and col%K==K-1:
  - The combined value is not written back.
  - It is registered to out_data on the next edge with out_valid=1. Latency is 1 cycle after the completing beat.
  - Max mode: out_data is the low W bits of the combined value (it already fits).
  - Avg mode: out_data is the combined sum >>> 2*log2(K) (arithmetic shift, rounds toward −inf), truncated to W bits.
  - out_row = row/K and out_col = col/K for the completing beat.
- **out_valid** is high for exactly one cycle per pooled pixel, OW² pulses per frame.
- **finish** is asserted in the same cycle as out_valid for pooled pixel (OW-1, OW-1). It is 0 otherwise.
- **Back-to-back frames.** The first pixel of frame n+1 may arrive in the cycle after the last pixel of frame n. The out_valid/finish of frame n and the buffer load of frame n+1 occur without conflict.
- **Saturation.** No saturation anywhere. Sums cannot overflow A bits by construction.

Test Plan:
- **Max mode basic.** C=2, W=8, IM=4, K=2, mode=0. ch0 rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; ch1 = −ch0.
  - Required: 4 out_valid pulses.
  - ch0 = 6, 8, 14, 16.
  - ch1 = −1, −3, −9, −11.
  - (out_row,out_col) = (0,0),(0,1),(1,0),(1,1).
  - finish only with the 4th pulse.
- **Avg mode.** Same stimulus, mode=1.
  - ch0 = 3 (14>>>2), 5, 11, 13.
  - ch1 = −4 (−14>>>2), −6, −12, −14.
- **Odd size.** IM=5, K=2, continuous beats.
  - Required: exactly 4 outputs per frame.
  - Column 4 and row 4 pixels are ignored.
  - finish is asserted 1 cycle after beat index 18, i.e. pixel (3,3).
- **Gaps and mode change.**
  - Stimulus: insert random in_valid=0 bubbles; toggle mode mid-frame.
  - Required: outputs identical to the gap-free run with the frame-start mode.
- **Reset mid-frame.**
  - Stimulus: assert reset after 7 beats, then stream a full frame.
  - Required: out_valid/finish are 0 the cycle after reset; the new frame yields exactly OW² correct outputs.
- **Back-to-back frames.**
  - Stimulus: two frames streamed continuously, second with values +100.
  - Required: 8 outputs in total, second-frame results +100 relative to the first, and two finish pulses.
